noise_est_sequencer: RTL and testbench

NOISE_EST_SEQUENCER -- requirements
Module: noise_est_sequencer

---
 rtl/noise_est_sequencer.sv | 138 +++++++++++++
 tb/tb_noise_est_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_est_sequencer.sv
// Noise-estimator sequencer: frames the incoming pixel stream into blocks for
// an external noise estimator, then waits (bounded) for the frame result.
module noise_est_sequencer #(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned TOTAL_SAMPLES    = 4,
  parameter int unsigned BLOCKS_PER_FRAME = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic                    ne_start_of_frame,
  output logic                    ne_end_of_frame,
  output logic                    ne_start_data,
  output logic                    ne_end_data,
  output logic                    ne_data_valid,
  output logic [DATA_WIDTH-1:0]   ne_data,
  input  logic [2*DATA_WIDTH-1:0] estimated_noise,
  input  logic                    estimated_noise_ready,
  output logic [2*DATA_WIDTH-1:0] noise_out,
  output logic                    noise_valid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             frames_done
);

  localparam int unsigned SW = $clog2(TOTAL_SAMPLES + 1);
  localparam int unsigned BW = $clog2(BLOCKS_PER_FRAME + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, END, WAIT_RES} state_t;

  state_t        state;
  logic [SW-1:0] sample_cnt;
  logic [BW-1:0] block_cnt;
  logic [TW-1:0] wait_cnt;

  // Single-process FSM; every output is a register updated with the state
  // being entered so it is valid for the whole cycle spent in that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      sample_cnt        <= '0;
      block_cnt         <= '0;
      wait_cnt          <= '0;
      pix_ready         <= 1'b0;
      ne_start_of_frame <= 1'b0;
      ne_end_of_frame   <= 1'b0;
      ne_start_data     <= 1'b0;
      ne_end_data       <= 1'b0;
      ne_data_valid     <= 1'b0;
      ne_data           <= '0;
      noise_out         <= '0;
      noise_valid       <= 1'b0;
      busy              <= 1'b0;
      timeout_err       <= 1'b0;
      frames_done       <= '0;
    end else begin
      ne_start_of_frame <= 1'b0;
      ne_start_data     <= 1'b0;
      ne_end_data       <= 1'b0;
      ne_data_valid     <= 1'b0;
      noise_valid       <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state             <= START;
            busy              <= 1'b1;
            timeout_err       <= 1'b0;
            ne_start_data     <= 1'b1;
            ne_start_of_frame <= (block_cnt == '0);
            ne_end_of_frame   <= (BLOCKS_PER_FRAME == 1);
          end
        end

        START: begin
          state     <= DATA;
          pix_ready <= 1'b1;
        end

        DATA: begin
          if (pix_valid) begin
            ne_data       <= pix_in;
            ne_data_valid <= 1'b1;
            sample_cnt    <= SW'(sample_cnt + SW'(1));
            if (sample_cnt == SW'(TOTAL_SAMPLES - 1)) begin
              state       <= END;
              pix_ready   <= 1'b0;
              ne_end_data <= 1'b1;
            end
          end
        end

        END: begin
          sample_cnt <= '0;
          if (block_cnt != BW'(BLOCKS_PER_FRAME - 1)) begin
            block_cnt       <= BW'(block_cnt + BW'(1));
            state           <= START;
            ne_start_data   <= 1'b1;
            ne_end_of_frame <= (BW'(block_cnt + BW'(1)) == BW'(BLOCKS_PER_FRAME - 1));
          end else begin
            block_cnt       <= '0;
            state           <= WAIT_RES;
            ne_end_of_frame <= 1'b0;
            wait_cnt        <= '0;
          end
        end

        WAIT_RES: begin
          if (estimated_noise_ready) begin
            noise_out   <= estimated_noise;
            noise_valid <= 1'b1;
            frames_done <= frames_done + 16'd1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= TW'(wait_cnt + TW'(1));
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noise_est_sequencer.sv
// Directed bench for noise_est_sequencer with a sample scoreboard.
module tb_noise_est_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned NW  = 2 * DW;
  localparam int          TS  = 4;
  localparam int          BPF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          ne_start_of_frame, ne_end_of_frame, ne_start_data, ne_end_data, ne_data_valid;
  logic [DW-1:0] ne_data;
  logic [NW-1:0] estimated_noise;
  logic          estimated_noise_ready;
  logic [NW-1:0] noise_out;
  logic          noise_valid, busy, timeout_err;
  logic [15:0]   frames_done;

  noise_est_sequencer #(
    .DATA_WIDTH(DW), .TOTAL_SAMPLES(TS), .BLOCKS_PER_FRAME(BPF), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .ne_start_of_frame(ne_start_of_frame), .ne_end_of_frame(ne_end_of_frame),
    .ne_start_data(ne_start_data), .ne_end_data(ne_end_data),
    .ne_data_valid(ne_data_valid), .ne_data(ne_data),
    .estimated_noise(estimated_noise), .estimated_noise_ready(estimated_noise_ready),
    .noise_out(noise_out), .noise_valid(noise_valid), .busy(busy),
    .timeout_err(timeout_err), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  // Monitor state (written only by the monitor process)
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic          eof_exp;
  int acc_total = 0, mon_cmp = 0, mon_err = 0;
  int sd_cnt = 0, ed_cnt = 0, sof_cnt = 0, eof_cyc = 0, nv_cnt = 0, dat_cnt = 0;
  int frame_dat = 0, blk_dat = 0, gap = 0, gap3_cnt = 0, gapx_cnt = 0;
  bit inb = 1'b0;

  // Sequence state (written only by the stimulus process)
  int n_cmp = 0, n_err = 0;
  int s_sd, s_ed, s_sof, s_eof, s_nv, s_dat, s_g3, s_gx;
  int n;

  // Posedge: record accepted pixels; negedge: score outputs and count framing
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (rst) exp_q.delete();
      else if (pix_valid && pix_ready) begin
        exp_q.push_back(pix_in);
        acc_total++;
      end
    end else if (!rst) begin
      if (ne_start_of_frame) begin sof_cnt++; frame_dat = 0; end
      if (ne_start_data) begin sd_cnt++; blk_dat = 0; end
      if (ne_end_of_frame) eof_cyc++;
      if (noise_valid) nv_cnt++;
      if (ne_data_valid) begin
        mon_cmp++;
        assert (exp_q.size() != 0) else begin
          mon_err++;
          $error("FAIL ne_data_unexpected: observed 0x%0h expected none", ne_data);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          mon_cmp++;
          assert (ne_data === exp_v) else begin
            mon_err++;
            $error("FAIL ne_data: observed 0x%0h expected 0x%0h", ne_data, exp_v);
          end
        end
        eof_exp = (frame_dat >= TS * (BPF - 1));
        mon_cmp++;
        assert (ne_end_of_frame === eof_exp) else begin
          mon_err++;
          $error("FAIL ne_end_of_frame: observed %b expected %b (sample %0d)", ne_end_of_frame, eof_exp, frame_dat);
        end
        if (inb) begin
          if (gap == 3) gap3_cnt++;
          else if (gap != 0) gapx_cnt++;
        end
        gap = 0; inb = 1'b1;
        frame_dat++; blk_dat++; dat_cnt++;
      end else if (inb) gap++;
      if (ne_end_data) begin
        mon_cmp++;
        assert (blk_dat === TS) else begin
          mon_err++;
          $error("FAIL block_samples: observed %0d expected %0d", blk_dat, TS);
        end
        inb = 1'b0;
      end
    end else inb = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_sd = sd_cnt; s_ed = ed_cnt; s_sof = sof_cnt; s_eof = eof_cyc;
    s_nv = nv_cnt; s_dat = dat_cnt; s_g3 = gap3_cnt; s_gx = gapx_cnt;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Feed pixels offs+1.. until 'upto' are accepted; optional 3-cycle stall
  // at sample index stall_at and one stray frame_start at index fs_at.
  task automatic run_pixels(input int offs, input int stall_at, input int fs_at, input int upto);
    int base = acc_total;
    int stall_left = 3;
    bit fs_done = 1'b0;
    int k;
    for (int c = 0; c < 400; c++) begin
      k = acc_total - base;
      if (k >= upto) break;
      frame_start = (k == fs_at) && !fs_done;
      if (frame_start) fs_done = 1'b1;
      if (k == stall_at && stall_left > 0) begin
        pix_valid = 1'b0;
        stall_left--;
      end else pix_valid = 1'b1;
      pix_in = DW'(offs + k + 1);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    frame_start = 1'b0;
    chk("pixels_accepted", acc_total - base, upto);
  endtask

  task automatic give_result(input logic [NW-1:0] v, input int dly);
    repeat (dly) @(posedge clk);
    #1;
    estimated_noise = v;
    estimated_noise_ready = 1'b1;
    @(posedge clk); #1;
    estimated_noise_ready = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_framing(input int eof_exp_cyc, input int g3_exp);
    chk("start_data_pulses", sd_cnt - s_sd, BPF);
    chk("end_data_pulses", ed_cnt - s_ed, BPF);
    chk("start_of_frame_pulses", sof_cnt - s_sof, 1);
    chk("end_of_frame_cycles", eof_cyc - s_eof, eof_exp_cyc);
    chk("samples_out", dat_cnt - s_dat, TS * BPF);
    chk("stall_gaps", gap3_cnt - s_g3, g3_exp);
    chk("other_gaps", gapx_cnt - s_gx, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  // ne_end_data pulses are counted here so the monitor stays single-purpose
  always @(negedge clk) if (!rst && ne_end_data) ed_cnt <= ed_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; pix_in = '0; pix_valid = 1'b0;
    estimated_noise = '0; estimated_noise_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_noise_out", noise_out, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: continuous pixels 1..16, result 0x0042
    snap();
    start_frame();
    run_pixels(0, -1, -1, TS * BPF);
    give_result(16'h0042, 3);
    wait_idle(50, n);
    chk_framing(6, 0);
    chk("f1_noise_out", noise_out, 32'h0042);
    chk("f1_noise_valid_pulses", nv_cnt - s_nv, 1);
    chk("f1_frames_done", frames_done, 1);
    chk("f1_timeout_err", timeout_err, 0);

    // Frame 2: 3-cycle stall after sample 2, stray frame_start in DATA
    snap();
    start_frame();
    run_pixels(32'h20, 2, 6, TS * BPF);
    give_result(16'h0077, 3);
    wait_idle(50, n);
    chk_framing(6, 1);
    chk("f2_noise_out", noise_out, 32'h0077);
    chk("f2_noise_valid_pulses", nv_cnt - s_nv, 1);
    chk("f2_frames_done", frames_done, 2);

    // Frame 3: estimator never answers
    snap();
    start_frame();
    run_pixels(32'h40, -1, -1, TS * BPF);
    wait_idle(1200, n);
    chk("f3_timeout_window", 32'((n >= 1024) && (n <= 1028)), 1);
    chk("f3_timeout_err", timeout_err, 1);
    chk("f3_noise_out_kept", noise_out, 32'h0077);
    chk("f3_frames_done", frames_done, 2);
    chk("f3_no_noise_valid", nv_cnt - s_nv, 0);

    // frame_start together with a stray ready in IDLE
    snap();
    estimated_noise = 16'h1234;
    estimated_noise_ready = 1'b1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    estimated_noise_ready = 1'b0;
    @(negedge clk);
    chk("f4_timeout_cleared", timeout_err, 0);
    chk("f4_busy", busy, 1);
    chk("f4_start_of_frame", ne_start_of_frame, 1);
    @(posedge clk); #1;
    chk("f4_no_noise_valid", nv_cnt - s_nv, 0);
    chk("f4_noise_out_kept", noise_out, 32'h0077);

    // Reset in block 2 DATA
    run_pixels(32'h60, -1, -1, TS + 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix_ready", pix_ready, 0);
    chk("mid_rst_data_valid", ne_data_valid, 0);
    chk("mid_rst_ne_data", ne_data, 0);
    chk("mid_rst_eof", ne_end_of_frame, 0);
    chk("mid_rst_noise_out", noise_out, 0);
    chk("mid_rst_frames_done", frames_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fresh frame after reset
    snap();
    start_frame();
    @(negedge clk);
    chk("f5_start_of_frame", ne_start_of_frame, 1);
    chk("f5_start_data", ne_start_data, 1);
    @(posedge clk); #1;
    run_pixels(32'h80, -1, -1, TS * BPF);
    give_result(16'h0055, 3);
    wait_idle(50, n);
    chk_framing(6, 0);
    chk("f5_noise_out", noise_out, 32'h0055);
    chk("f5_frames_done", frames_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + mon_cmp, n_err + mon_err);
    $finish;
  end

endmodule
